// File: rtl/tft_ctrl.sv
// 480x272 TFT timing generator: sync/DE decode from free-running line/frame
// counters, one-clock-early pixel requests, and panel output gating.
module tft_ctrl #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_VALID = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_VALID = 272,
    parameter int V_FRONT = 2
) (
    input  logic        tft_clk_9m,
    input  logic        sys_rst,
    input  logic [23:0] rgb_data,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb_tft,
    output logic        tft_de,
    output logic        tft_clk,
    output logic        tft_bl,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_DE_LO   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_DE_HI   = 12'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [11:0] H_REQ_LO  = 12'(H_SYNC + H_BACK - 1);
    localparam logic [11:0] H_REQ_HI  = 12'(H_SYNC + H_BACK + H_VALID - 2);
    localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC + V_BACK + V_VALID - 1);
    localparam logic [11:0] NO_PIXEL  = 12'hFFF;

    logic [11:0] cnt_h;
    logic [11:0] cnt_v;
    logic        h_de;
    logic        h_req;
    logic        v_act;
    logic        req_win;

    function automatic logic in_range(input logic [11:0] val,
                                      input logic [11:0] lo,
                                      input logic [11:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Counter stage: cnt_v steps on the same edge that wraps cnt_h.
    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? 12'd0 : cnt_v + 12'd1;
        end else begin
            cnt_h <= cnt_h + 12'd1;
        end
    end

    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst) begin
            tft_bl <= 1'b0;
        end else begin
            tft_bl <= 1'b1;
        end
    end

    // Decode stage: requests run one clock ahead of DE so the renderer's
    // registered colour lands exactly in the DE cycle.
    always_comb begin
        h_de    = in_range(cnt_h, H_DE_LO, H_DE_HI);
        h_req   = in_range(cnt_h, H_REQ_LO, H_REQ_HI);
        v_act   = in_range(cnt_v, V_ACT_LO, V_ACT_HI);
        req_win = h_req && v_act;

        hsync       = (cnt_h < 12'(H_SYNC));
        vsync       = (cnt_v < 12'(V_SYNC));
        tft_de      = h_de && v_act;
        pix_x       = req_win ? (cnt_h - H_REQ_LO) : NO_PIXEL;
        pix_y       = req_win ? (cnt_v - V_ACT_LO) : NO_PIXEL;
        rgb_tft     = tft_de ? rgb_data : 24'h000000;
        frame_start = (cnt_h == 12'd0) && (cnt_v == 12'd0) && !sys_rst;
    end

    assign tft_clk = tft_clk_9m;

endmodule

// File: tb/tb_tft_ctrl.sv
// Directed bench for tft_ctrl: default horizontal timing with a shortened
// vertical frame so several whole frames fit in a short run.
module tb_tft_ctrl;

    localparam int HS = 41, HB = 2, HV = 480, HF = 2;
    localparam int VS = 3,  VB = 2, VV = 5,   VF = 2;
    localparam int HT = HS + HB + HV + HF;   // 525
    localparam int VT = VS + VB + VV + VF;   // 12
    localparam int ROW0 = VS + VB;           // first active line (5)
    localparam int ROWN = VS + VB + VV - 1;  // last active line (9)

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [23:0] rgb_data = '0;
    logic [11:0] pix_x, pix_y;
    logic        hsync, vsync, tft_de, tft_clk, tft_bl, frame_start;
    logic [23:0] rgb_tft;

    always #5 clk = ~clk;

    tft_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
    ) dut (
        .tft_clk_9m (clk),
        .sys_rst    (sys_rst),
        .rgb_data   (rgb_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb_tft    (rgb_tft),
        .tft_de     (tft_de),
        .tft_clk    (tft_clk),
        .tft_bl     (tft_bl),
        .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Renderer stand-in: colour = one-cycle-registered {pix_x, pix_y}.
    logic [23:0] rgb_nxt;
    initial begin
        forever begin
            @(negedge clk);
            rgb_nxt = {pix_x, pix_y};
            @(posedge clk);
            rgb_data = rgb_nxt;
        end
    end

    // Reference position and backlight, advanced on every rising edge.
    int mh = 0, mv = 0;
    bit mbl = 1'b0;
    bit live = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            if (sys_rst) begin
                mh = 0; mv = 0; mbl = 1'b0;
            end else begin
                mbl = 1'b1;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
            live = 1'b1;
        end
    end

    // Per-clock output check plus frame statistics.
    int since = 0, vs_acc = 0, last_gap = 0, last_vs = 0, fs_cnt = 0;
    bit vwin, de_e, rq_e, fs_e;
    logic [11:0] px_e, py_e;
    logic [23:0] rgb_e;
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                vwin  = (mv >= ROW0) && (mv <= ROWN);
                de_e  = vwin && (mh >= 43) && (mh <= 522);
                rq_e  = vwin && (mh >= 42) && (mh <= 521);
                px_e  = rq_e ? 12'(mh - 42) : 12'hFFF;
                py_e  = rq_e ? 12'(mv - ROW0) : 12'hFFF;
                rgb_e = de_e ? {12'(mh - 43), 12'(mv - ROW0)} : 24'h0;
                fs_e  = (mh == 0) && (mv == 0) && !sys_rst;
                chk("hsync", 32'(hsync), 32'(mh < HS));
                chk("vsync", 32'(vsync), 32'(mv < VS));
                chk("tft_de", 32'(tft_de), 32'(de_e));
                chk("pix_x", 32'(pix_x), 32'(px_e));
                chk("pix_y", 32'(pix_y), 32'(py_e));
                chk("rgb_tft", 32'(rgb_tft), 32'(rgb_e));
                chk("frame_start", 32'(frame_start), 32'(fs_e));
                chk("tft_bl", 32'(tft_bl), 32'(mbl));
                chk("tft_clk", 32'(tft_clk), 32'(clk));
                if (frame_start) begin
                    last_gap = since;
                    last_vs  = vs_acc;
                    since    = 0;
                    vs_acc   = 0;
                    fs_cnt++;
                end
                since++;
                vs_acc += int'(vsync);
            end
        end
    end

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 15000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_pos", 32'(mh == h && mv == v), 32'd1);
    endtask

    task automatic wait_fs(input int target);
        int n = 0;
        while (fs_cnt < target && n < 15000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_fs", 32'(fs_cnt >= target), 32'd1);
    endtask

    int cnt, de_first, de_last, k;

    initial begin
        // Reset held for five edges; the last one releases at +2.
        repeat (4) begin
            @(posedge clk);
            @(negedge clk); #1;
            chk("rst_hsync", 32'(hsync), 32'd1);
            chk("rst_vsync", 32'(vsync), 32'd1);
            chk("rst_de", 32'(tft_de), 32'd0);
            chk("rst_pix_x", 32'(pix_x), 32'hFFF);
            chk("rst_bl", 32'(tft_bl), 32'd0);
            chk("rst_fs", 32'(frame_start), 32'd0);
            chk("rst_rgb", 32'(rgb_tft), 32'd0);
        end
        @(posedge clk); #2 sys_rst = 1'b0;
        @(negedge clk); #1;
        chk("rel_fs", 32'(frame_start), 32'd1);
        chk("rel_vsync", 32'(vsync), 32'd1);
        @(negedge clk); #1;
        chk("rel_bl", 32'(tft_bl), 32'd1);
        chk("rel_fs_once", 32'(frame_start), 32'd0);

        // hsync width over one full line
        wait_pos(0, 1);
        cnt = 0;
        for (int i = 0; i < HT; i++) begin
            cnt += int'(hsync);
            @(negedge clk); #1;
        end
        chk("hs_per_line", 32'(cnt), 32'd41);

        // first active line: request and DE windows
        wait_pos(0, ROW0);
        cnt = 0; de_first = -1; de_last = -1;
        for (int i = 0; i < HT; i++) begin
            if (mh == 42) begin
                chk("px_first", 32'(pix_x), 32'd0);
                chk("py_first", 32'(pix_y), 32'd0);
            end
            if (mh == 521) chk("px_last", 32'(pix_x), 32'd479);
            if (mh == 43) chk("rgb_first", 32'(rgb_tft), 32'h000000);
            if (tft_de) begin
                cnt++;
                if (de_first < 0) de_first = mh;
                de_last = mh;
            end
            @(negedge clk); #1;
        end
        chk("de_per_line", 32'(cnt), 32'd480);
        chk("de_first_h", 32'(de_first), 32'd43);
        chk("de_last_h", 32'(de_last), 32'd522);

        wait_pos(42, ROWN);
        chk("py_lastrow", 32'(pix_y), 32'(VV - 1));
        wait_pos(522, ROWN);
        chk("rgb_last", 32'(rgb_tft), {8'h0, 12'd479, 12'(VV - 1)});
        @(negedge clk); #1;
        chk("de_after", 32'(tft_de), 32'd0);
        chk("rgb_after", 32'(rgb_tft), 32'd0);
        wait_pos(42, VT - 1);
        chk("py_front", 32'(pix_y), 32'hFFF);
        chk("px_front", 32'(pix_x), 32'hFFF);

        wait_fs(2);
        chk("frame_gap", 32'(last_gap), 32'(HT * VT));
        chk("vs_per_frame", 32'(last_vs), 32'(HT * VS));

        // one-clock reset in mid-frame
        wait_pos(299, 7);
        @(posedge clk); #2 sys_rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_in_rst_fs", 32'(frame_start), 32'd0);
        chk("mid_in_rst_h", 32'(hsync), 32'd0);
        @(posedge clk); #2 sys_rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_fs", 32'(frame_start), 32'd1);
        chk("mid_vsync", 32'(vsync), 32'd1);
        chk("mid_hsync", 32'(hsync), 32'd1);
        chk("mid_pix_x", 32'(pix_x), 32'hFFF);
        k = fs_cnt;
        wait_fs(k + 1);
        chk("mid_frame_gap", 32'(last_gap), 32'(HT * VT));
        chk("mid_vs_frame", 32'(last_vs), 32'(HT * VS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
